serial_add_ctrl: RTL and testbench
==================================

Name: serial_add_ctrl

Overview:
- Bit-serial adder controller: a single `full_adder` instance computes a WIDTH-bit sum over WIDTH clock cycles, one bit per cycle, least significant bit (LSB) first.
- It captures the operands, shifts bits into the adder, registers the carry between cycles and presents the result with a start/done handshake.
- It is the area-minimal alternative to a ripple-carry array; any block that needs occasional wide adds can use it.

Parameters:
- WIDTH, 8, operand and sum width in bits; legal range 2..32.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request a new addition; honoured only when ready=1.
- a  input  WIDTH  operand A; sampled on the edge where start&&ready.
- b  input  WIDTH  operand B; sampled with a.
- cin  input  1  carry-in; sampled with a.
- ready  output  1  high in IDLE only.
- busy  output  1  high in ADD only.
- done  output  1  one-cycle pulse: result valid.
- sum  output  WIDTH  registered result; holds until the next result is written.
- cout  output  1  registered final carry-out; same timing as sum.

Behaviour:
- Reset (async, on rst high):
  - state=IDLE; ready=1, busy=0, done=0; sum=0, cout=0.
  - Internal shift registers, carry register and bit counter are all cleared.
- Datapath:
  - Instantiate exactly one `full_adder`. Its inputs are shA[0], shB[0] and the carry register.
  - Each ADD cycle:
    - shA and shB shift right by 1.
    - The adder's sum bit enters shS at the MSB, shifting shS right.
    - The carry register takes the adder's carry output.
- States:
  - IDLE:
    - On start: load shA=a, shB=b, carry=cin; clear shS and cnt; go to ADD.
    - Otherwise stay in IDLE.
  - ADD:
    - One bit per cycle; cnt increments, width clog2(WIDTH)+1.
    - On the edge that processes bit WIDTH-1 (cnt==WIDTH-1): write sum = final shS (including this bit) and cout = new carry; go to DONE.
  - DONE: done=1 for exactly one cycle; next edge goes to IDLE unconditionally.
- Latency and throughput:
  - Accept edge E0 → ADD edges E1..E_WIDTH → done high in the cycle after E_WIDTH.
  - That is WIDTH+1 cycles from accept to done, counting the done cycle.
  - Next accept possible at E_(WIDTH+2); throughput one add per WIDTH+2 cycles.
- Result rules:
  - sum and cout change only on entry to DONE (or on reset).
  - Partial results are never visible on sum/cout.
  - They stay stable through IDLE until the next completion.
- Arithmetic: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1); no overflow flag.
- Boundary conditions:
  - start while ADD or DONE: ignored; no queuing, no effect on the current operation.
  - a/b/cin changing after accept: no effect; only the sampled copies are used.
  - start held high continuously: a new operation is accepted on every IDLE cycle, giving back-to-back ops at WIDTH+2 spacing.
  - rst mid-ADD: aborts immediately; no done pulse; sum/cout clear to 0.
  - rst during DONE: done drops asynchronously.
- Outputs ready/busy/done decode directly from the state register; no combinational path from start.

Test Plan (WIDTH=8):
- Reset, then a=0x00, b=0x00, cin=0, start 1 cycle → ready drops the next cycle; busy for 8 cycles; done pulse exactly 9 cycles after accept; sum=0x00, cout=0.
- a=0xFF, b=0x01, cin=0 → sum=0x00, cout=1. Then a=0xA5, b=0x5A, cin=1 → sum=0x00, cout=1. Then a=0x3C, b=0x0F, cin=0 → sum=0x4B, cout=0.
- Pulse start at cycles 3 and 7 of an ADD with different operands → result matches the first operands only; exactly one done pulse; ready returns 1 the cycle after done.
- Assert rst for 1 cycle at ADD cycle 4 → outputs go to reset values asynchronously; no done pulse; a following op 0x12+0x34 gives sum=0x46, cout=0.
- Hold start high with operands changing every cycle for 3 ops → accepts spaced exactly 10 cycles apart; each result matches the operands sampled at its accept edge; sum stays stable between done pulses.
- WIDTH=4 build, all 512 combinations of a, b, cin → {cout,sum} equals a+b+cin for every case, each with a single done pulse.

Source files
------------

// File: rtl/serial_add_ctrl_if.sv
// Start/done handshake and operand/result bus for serial_add_ctrl.
// The requester uses master; the adder uses slave.
interface serial_add_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output start, a, b, cin,
        input  ready, busy, done, sum, cout
    );

    modport slave (
        input  start, a, b, cin,
        output ready, busy, done, sum, cout
    );
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one full adder, LSB first, WIDTH cycles per add.
// Result and carry are registered and only updated on entry to DONE.
module full_adder (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic co_o
);
    assign s_o  = a_i ^ b_i ^ c_i;
    assign co_o = (a_i & b_i) | (c_i & (a_i ^ b_i));
endmodule

module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input logic          clk,
    input logic          rst,
    serial_add_ctrl_if.slave bus
);
    localparam int CW = $clog2(WIDTH) + 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ADD  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] sha_q, sha_d;
    logic [WIDTH-1:0] shb_q, shb_d;
    logic [WIDTH-1:0] shs_q, shs_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             fa_s, fa_co;

    full_adder u_fa (
        .a_i  (sha_q[0]),
        .b_i  (shb_q[0]),
        .c_i  (carry_q),
        .s_o  (fa_s),
        .co_o (fa_co)
    );

    always_comb begin
        state_d = state_q;
        sha_d   = sha_q;
        shb_d   = shb_q;
        shs_d   = shs_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    sha_d   = bus.a;
                    shb_d   = bus.b;
                    carry_d = bus.cin;
                    shs_d   = '0;
                    cnt_d   = '0;
                    state_d = ADD;
                end
            end
            ADD: begin
                sha_d   = sha_q >> 1;
                shb_d   = shb_q >> 1;
                shs_d   = {fa_s, shs_q[WIDTH-1:1]};
                carry_d = fa_co;
                cnt_d   = cnt_q + 1'b1;
                // Last bit: publish the completed word and final carry.
                if (cnt_q == CW'(WIDTH - 1)) begin
                    sum_d   = shs_d;
                    cout_d  = fa_co;
                    state_d = DONE;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sha_q   <= '0;
            shb_q   <= '0;
            shs_q   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sha_q   <= sha_d;
            shb_q   <= shb_d;
            shs_q   <= shs_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.ready = (state_q == IDLE);
    assign bus.busy  = (state_q == ADD);
    assign bus.done  = (state_q == DONE);
    assign bus.sum   = sum_q;
    assign bus.cout  = cout_q;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl: 8-bit vector table and corner
// sequences, plus an exhaustive 4-bit instance.
module tb_serial_add_ctrl;
    logic clk;
    logic rst;
    int   total;
    int   bad;

    serial_add_ctrl_if #(.WIDTH(8)) bus8 ();
    serial_add_ctrl_if #(.WIDTH(4)) bus4 ();

    serial_add_ctrl #(.WIDTH(8)) dut8 (
        .clk (clk),
        .rst (rst),
        .bus (bus8.slave)
    );

    serial_add_ctrl #(.WIDTH(4)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] esum;
        logic       ecout;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic op8(input logic [7:0] a, input logic [7:0] b,
                       input logic c, input logic [7:0] es,
                       input logic ec, input string nm);
        int   k;
        int   nb;
        bit   seen;
        bit   held;
        logic [7:0] prev;
        @(negedge clk);
        chk({nm, " ready_idle"}, 32'(bus8.ready), 32'd1);
        prev       = bus8.sum;
        bus8.start = 1'b1;
        bus8.a     = a;
        bus8.b     = b;
        bus8.cin   = c;
        @(negedge clk);
        bus8.start = 1'b0;
        bus8.a     = ~a;
        bus8.b     = a ^ b ^ 8'h5A;
        bus8.cin   = ~c;
        chk({nm, " ready_drop"}, 32'(bus8.ready), 32'd0);
        k    = 0;
        nb   = 0;
        seen = 1'b0;
        held = 1'b1;
        while (!seen && k < 20) begin
            if (bus8.busy) nb++;
            if (bus8.done) begin
                seen = 1'b1;
            end else begin
                if (bus8.sum !== prev) held = 1'b0;
                @(negedge clk);
                k++;
            end
        end
        chk({nm, " latency"}, 32'(k), 32'd8);
        chk({nm, " busy_cycles"}, 32'(nb), 32'd8);
        chk({nm, " sum_held"}, 32'(held), 32'd1);
        chk({nm, " result"}, 32'({bus8.cout, bus8.sum}), 32'({ec, es}));
        @(negedge clk);
        chk({nm, " done_pulse"}, 32'(bus8.done), 32'd0);
        chk({nm, " ready_back"}, 32'(bus8.ready), 32'd1);
    endtask

    task automatic op4(input logic [3:0] a, input logic [3:0] b,
                       input logic c);
        int   k;
        logic [4:0] exp;
        logic ok;
        @(negedge clk);
        bus4.start = 1'b1;
        bus4.a     = a;
        bus4.b     = b;
        bus4.cin   = c;
        @(negedge clk);
        bus4.start = 1'b0;
        bus4.a     = ~a;
        k = 0;
        while (!bus4.done && k < 12) begin
            @(negedge clk);
            k++;
        end
        exp = 5'(a) + 5'(b) + 5'(c);
        ok  = bus4.done && (k == 4);
        @(negedge clk);
        ok  = ok && !bus4.done;
        chk($sformatf("w4 %h+%h+%b", a, b, c),
            32'({ok, bus4.cout, bus4.sum}), 32'({1'b1, exp}));
    endtask

    initial begin
        int nd;
        int dk;
        int acc;
        int dones;
        int last;
        int sbad;
        logic [7:0] held;
        logic [8:0] q[$];
        logic [8:0] e9;

        total = 0;
        bad   = 0;
        vecs[0] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        vecs[2] = '{8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1};
        vecs[3] = '{8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0};
        vecs[4] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        vecs[5] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};
        vecs[6] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
        vecs[7] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};

        rst        = 1'b1;
        bus8.start = 1'b0;
        bus8.a     = '0;
        bus8.b     = '0;
        bus8.cin   = 1'b0;
        bus4.start = 1'b0;
        bus4.a     = '0;
        bus4.b     = '0;
        bus4.cin   = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst ready", 32'(bus8.ready), 32'd1);
        chk("rst busy", 32'(bus8.busy), 32'd0);
        chk("rst done", 32'(bus8.done), 32'd0);
        chk("rst result", 32'({bus8.cout, bus8.sum}), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++)
            op8(vecs[i].a, vecs[i].b, vecs[i].cin,
                vecs[i].esum, vecs[i].ecout, $sformatf("vec%0d", i));

        // start pulses during ADD must be ignored
        @(negedge clk);
        bus8.start = 1'b1;
        bus8.a     = 8'h21;
        bus8.b     = 8'h43;
        bus8.cin   = 1'b1;
        @(negedge clk);
        nd = 0;
        dk = -10;
        for (int k = 0; k < 15; k++) begin
            if (bus8.done) begin
                nd++;
                dk = k;
            end
            if (k == dk + 1)
                chk("ign ready_after", 32'(bus8.ready), 32'd1);
            if (k == 3 || k == 7) begin
                bus8.start = 1'b1;
                bus8.a     = 8'hFF;
                bus8.b     = 8'hEE;
                bus8.cin   = 1'b0;
            end else begin
                bus8.start = 1'b0;
            end
            @(negedge clk);
        end
        chk("ign done_count", 32'(nd), 32'd1);
        chk("ign done_idx", 32'(dk), 32'd8);
        chk("ign result", 32'({bus8.cout, bus8.sum}), 32'h065);

        // asynchronous reset mid-ADD
        bus8.start = 1'b1;
        bus8.a     = 8'h77;
        bus8.b     = 8'h11;
        bus8.cin   = 1'b0;
        @(negedge clk);
        bus8.start = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst ready", 32'(bus8.ready), 32'd1);
        chk("arst busy", 32'(bus8.busy), 32'd0);
        chk("arst result", 32'({bus8.cout, bus8.sum}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        nd  = 0;
        for (int k = 0; k < 12; k++) begin
            if (bus8.done) nd++;
            @(negedge clk);
        end
        chk("arst no_done", 32'(nd), 32'd0);
        op8(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, "post_rst");

        // reset while in DONE
        @(negedge clk);
        bus8.start = 1'b1;
        bus8.a     = 8'h55;
        bus8.b     = 8'h22;
        @(negedge clk);
        bus8.start = 1'b0;
        for (int k = 0; k < 20 && !bus8.done; k++) @(negedge clk);
        chk("drst in_done", 32'(bus8.done), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("drst done_drop", 32'(bus8.done), 32'd0);
        chk("drst result", 32'({bus8.cout, bus8.sum}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // start held high with operands changing every cycle
        acc   = 0;
        dones = 0;
        last  = -1;
        sbad  = 0;
        held  = bus8.sum;
        bus8.start = 1'b1;
        for (int c = 0; c < 60 && dones < 3; c++) begin
            if (bus8.done) begin
                e9 = (q.size() > 0) ? q.pop_front() : 9'h1FF;
                chk($sformatf("hold res%0d", dones),
                    32'({bus8.cout, bus8.sum}), 32'(e9));
                dones++;
                held = bus8.sum;
            end else if (bus8.sum !== held) begin
                sbad++;
            end
            if (acc < 3) begin
                bus8.a   = 8'(c * 37 + 5);
                bus8.b   = 8'(c * 91 + 13);
                bus8.cin = c[0];
                if (bus8.ready) begin
                    q.push_back(9'(bus8.a) + 9'(bus8.b) + 9'(bus8.cin));
                    if (last >= 0)
                        chk("hold spacing", 32'(c - last), 32'd10);
                    last = c;
                    acc++;
                end
            end else begin
                bus8.start = 1'b0;
            end
            @(negedge clk);
        end
        bus8.start = 1'b0;
        chk("hold dones", 32'(dones), 32'd3);
        chk("hold stable", 32'(sbad), 32'd0);

        for (int i = 0; i < 512; i++)
            op4(4'(i >> 5), 4'(i >> 1), i[0]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
